// File: rtl/gray_conv_arbiter.sv
// Round-robin shared gray-to-binary converter: grants one requester, converts its
// gray word serially MSB first, and returns the result with the requester ID.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] gray_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      bin_out,
  output logic [IDW-1:0]        out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int IXW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             chain_q, chain_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             found_s;
  logic [IDW-1:0]   pick_s;
  logic [IDW:0]     cand_s;
  logic             conv_bit_s;

  // Round-robin search: first requester at or above the pointer, wrapping modulo NREQ
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, ptr_q} + (IDW+1)'(i);
      cand_s = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
      pick_s  = (!found_s && req[cand_s[IDW-1:0]]) ? cand_s[IDW-1:0] : pick_s;
      found_s = found_s | req[cand_s[IDW-1:0]];
    end
  end

  // Next-state and datapath update for the IDLE/CONV/DONE sequence
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    chain_d    = chain_q;
    gray_d     = gray_q;
    id_d       = id_q;
    gnt_d      = '0;
    bin_d      = bin_q;
    out_id_d   = out_id_q;
    valid_d    = valid_q;
    conv_bit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          gray_d  = gray_in[pick_s*WIDTH +: WIDTH];
          id_d    = pick_s;
          gnt_d   = NREQ'(1) << pick_s;
          ptr_d   = (pick_s == IDW'(NREQ-1)) ? '0 : pick_s + IDW'(1);
          idx_d   = IXW'(WIDTH-1);
          acc_d   = '0;
          chain_d = 1'b0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        // chain_q holds the previously resolved (more significant) binary bit
        conv_bit_s   = gray_q[idx_q] ^ chain_q;
        acc_d[idx_q] = conv_bit_s;
        chain_d      = conv_bit_s;
        if (idx_q == IXW'(0)) begin
          bin_d    = acc_d;
          out_id_d = id_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      chain_q  <= 1'b0;
      gray_q   <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      bin_q    <= '0;
      out_id_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      chain_q  <= chain_d;
      gray_q   <= gray_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      bin_q    <= bin_d;
      out_id_q <= out_id_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign bin_out   = bin_q;
  assign out_id    = out_id_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus randomized
// transactions compared against an arithmetic round-robin / gray-decode model.
module tb_gray_conv_arbiter;

  localparam int W = 4;
  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   gray_in;
  logic [N-1:0]     gnt;
  logic [W-1:0]     bin_out;
  logic [IW-1:0]    out_id;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  logic [W-1:0]     gw [N];
  int               ptr_m;
  int               checks;
  int               errors;

  gray_conv_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gray_in   (gray_in),
    .gnt       (gnt),
    .bin_out   (bin_out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_gray();
    for (int k = 0; k < N; k++) gray_in[k*W +: W] = gw[k];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic txn(input logic [N-1:0] r, input int hold, output int waitc, output int got_id);
    int exp_id;
    logic [W-1:0] exp_bin;
    int n;
    req = r;
    out_ready = 1'b0;
    exp_id = rr_pick(r, ptr_m);
    exp_bin = g2b(gw[exp_id]);
    waitc = 0;
    do begin
      @(posedge clk); @(negedge clk); waitc++;
    end while (gnt == '0 && waitc < 20);
    chk("gnt", 32'(gnt), 32'(1) << exp_id);
    chk("busy_conv", 32'(busy), 32'd1);
    ptr_m = (exp_id + 1) % N;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!out_valid && n < 20);
    chk("latency", 32'(n), 32'(W));
    chk("gnt_pulse", 32'(gnt), 32'd0);
    chk("bin", 32'(bin_out), 32'(exp_bin));
    chk("id", 32'(out_id), 32'(exp_id));
    got_id = int'(out_id);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bin", 32'(bin_out), 32'(exp_bin));
      chk("hold_id", 32'(out_id), 32'(exp_id));
      chk("hold_gnt", 32'(gnt), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_gnt", 32'(gnt), 32'd0);
    chk("keep_bin", 32'(bin_out), 32'(exp_bin));
    out_ready = 1'b0;
  endtask

  initial begin
    int wc;
    int id;
    int seen_valid;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) gw[k] = '0;
    pack_gray();

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single request on channel 2, gray 1101 -> binary 1001
    gw[2] = 4'b1101;
    pack_gray();
    txn(4'b0100, 0, wc, id);
    chk("single_bin", 32'(bin_out), 32'b1001);
    chk("single_id", 32'(id), 32'd2);

    // Channel 0 sweeps the gray code sequence
    for (int k = 0; k < 16; k++) begin
      gw[0] = W'(k ^ (k >> 1));
      pack_gray();
      txn(4'b0001, 0, wc, id);
      chk("sweep_bin", 32'(bin_out), 32'(k));
    end

    // All requesters held high: strict rotation from pointer 0
    do_reset();
    for (int k = 0; k < N; k++) gw[k] = W'($urandom);
    pack_gray();
    for (int i = 0; i < 6; i++) begin
      txn(4'b1111, 0, wc, id);
      chk("rr_order", 32'(id), 32'(i % N));
      if (i > 0) chk("rr_gap", 32'(wc), 32'd1);
    end

    // Backpressure in DONE, then next grant one edge after the handshake
    txn(4'b1111, 10, wc, id);
    txn(4'b1111, 0, wc, id);
    chk("bp_next_gap", 32'(wc), 32'd1);

    // Reset during the second CONV cycle
    gw[2] = W'($urandom);
    pack_gray();
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'(1) << rr_pick(4'b0100, ptr_m));
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bin", 32'(bin_out), 32'd0);
    chk("mid_rst_id", 32'(out_id), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("mid_no_valid", 32'(seen_valid), 32'd0);
    txn(4'b1010, 0, wc, id);
    chk("post_rst_first", 32'(id), 32'd1);
    txn(4'b1010, 0, wc, id);
    chk("post_rst_second", 32'(id), 32'd3);

    // Pointer at 2 after granting channel 1: channel 3 before channel 1
    txn(4'b0010, 0, wc, id);
    txn(4'b1010, 0, wc, id);
    chk("ptr2_first", 32'(id), 32'd3);
    txn(4'b1010, 0, wc, id);
    chk("ptr2_second", 32'(id), 32'd1);

    // Randomized transactions against the model
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++) gw[k] = W'($urandom);
      pack_gray();
      txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)), wc, id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
